// File: rtl/mro_trng.sv
// mro_trng: multi-ring-oscillator TRNG with warmup, decimating sampler and hold/handshake FSM.
// Optional MRO_VON_NEUMANN_EN enables Von Neumann debiasing of the raw bit stream.
//
// state   | meaning
// IDLE    | rings held in reset, all progress cleared
// WARMUP  | rings run WARMUP_CYC cycles before sampling, busy=1
// COLLECT | raw bit sampled every SAMPLE_DIV cycles into the shift register
// HOLD    | completed word presented with data_valid until data_ready
module mro_trng #(
    parameter int N_RO       = 32,
    parameter int RO_LEN     = 20,
    parameter int WARMUP_CYC = 256,
    parameter int SAMPLE_DIV = 4,
    parameter int OUT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             data_ready,
    output logic [OUT_W-1:0] data_o,
    output logic             data_valid,
    output logic             busy,
    output logic [N_RO-1:0]  ro_clk_o
);

    localparam int WU_W  = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = $clog2(OUT_W);

    localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OUT_W - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, HOLD} state_t;

    state_t state, state_nxt;

    logic [WU_W-1:0]  wu_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [OUT_W-1:0] shreg;
    logic [N_RO-1:0]  sync1, sync2;
    logic             ring_rst;
    logic             clear_all, clear_cnt, load_word, release_word;
    logic             raw, tick, accept, bit_in;

    (* keep = "true" *) logic [N_RO-1:0] ring_out;

    assign ring_rst = !reset_n || (state == IDLE);

    // Each ring is a clocked RO_LEN-stage inverting loop model with a per-ring start
    // phase; the physical oscillator macro is bound in its place at implementation.
    for (genvar g = 0; g < N_RO; g++) begin : g_ring
        localparam logic [RO_LEN-2:0] SEED = (RO_LEN - 1)'(g * 37 + 5);
        logic [RO_LEN-1:0] stages;
        always_ff @(posedge clk) begin
            if (ring_rst) stages <= {1'b0, SEED};
            else          stages <= {stages[RO_LEN-2:0], ~stages[RO_LEN-1]};
        end
        assign ring_out[g] = stages[RO_LEN-1];
    end

    assign ro_clk_o = ring_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ro_clk_o;
            sync2 <= sync1;
        end
    end

    assign raw  = ^sync2;
    assign tick = (state == COLLECT) && (div_cnt == DIV_LAST);

`ifdef MRO_VON_NEUMANN_EN
    logic vn_have, vn_first;
    assign accept = tick && vn_have && (vn_first != raw);
    assign bit_in = vn_first;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_all || clear_cnt) begin
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if (tick) begin
            vn_have <= ~vn_have;
            if (!vn_have) vn_first <= raw;
        end
    end
`else
    assign accept = tick;
    assign bit_in = raw;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        clear_all    = 1'b0;
        clear_cnt    = 1'b0;
        load_word    = 1'b0;
        release_word = 1'b0;
        case (state)
            IDLE:    if (en) state_nxt = WARMUP;
            WARMUP:  if (wu_cnt == WU_LAST) begin
                         state_nxt = COLLECT;
                         clear_cnt = 1'b1;
                     end
            COLLECT: if (accept && (bit_cnt == BIT_LAST)) begin
                         state_nxt = HOLD;
                         load_word = 1'b1;
                     end
            HOLD:    if (data_ready) begin
                         state_nxt    = COLLECT;
                         release_word = 1'b1;
                         clear_cnt    = 1'b1;
                     end
            default: state_nxt = IDLE;
        endcase
        // Dropping en overrides everything, including a same-cycle handshake.
        if (!en) begin
            state_nxt    = IDLE;
            clear_all    = 1'b1;
            clear_cnt    = 1'b0;
            load_word    = 1'b0;
            release_word = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear_all) begin
            wu_cnt     <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_o     <= '0;
            data_valid <= 1'b0;
        end else begin
            if (clear_cnt) begin
                wu_cnt  <= '0;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                if (state == WARMUP)  wu_cnt  <= wu_cnt + WU_W'(1);
                if (state == COLLECT) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (accept)           bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
            end
            if (accept) shreg <= {shreg[OUT_W-2:0], bit_in};
            if (load_word) begin
                data_o     <= {shreg[OUT_W-2:0], bit_in};
                data_valid <= 1'b1;
            end else if (release_word) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == WARMUP);

endmodule

// File: tb/tb_mro_trng.sv
// Self-checking bench for mro_trng: rings are overridden with random or fixed patterns and
// every delivered word is predicted from the recorded ring history and the sampling schedule.
module tb_mro_trng;
    localparam int N = 32, WU = 256, DIV = 4, W = 32;

    logic         clk = 1'b0;
    logic         reset_n, en, data_ready;
    logic [W-1:0] data_o;
    logic         data_valid, busy;
    logic [N-1:0] ro_clk_o;

    mro_trng #(.N_RO(N), .RO_LEN(20), .WARMUP_CYC(WU), .SAMPLE_DIV(DIV), .OUT_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .data_ready(data_ready),
        .data_o(data_o), .data_valid(data_valid), .busy(busy), .ro_clk_o(ro_clk_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, edge_n = 0, ro_mode = 0, vn_base = 0;
    logic [N-1:0] ro_const = '0, force_val = '0;
    logic [N-1:0] hist [0:16383];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Ring source: 0 free-running, 1 random per cycle, 2 constant, 3 raw alternating every DIV edges.
    task automatic set_mode(input int m, input logic [N-1:0] c);
        ro_mode  = m;
        ro_const = c;
        if (m == 0) release dut.ro_clk_o;
    endtask

    // Drive inputs for the next rising edge, record the ring value it samples, return mid-cycle.
    task automatic cyc(input logic rst_v, input logic en_v, input logic rdy_v);
        reset_n    = rst_v;
        en         = en_v;
        data_ready = rdy_v;
        case (ro_mode)
            1:       force_val = $urandom;
            2:       force_val = ro_const;
            3:       force_val = (((edge_n + 1 - vn_base) / DIV) % 2 == 0) ? N'(1) : N'(0);
            default: force_val = '0;
        endcase
        if (ro_mode != 0) force dut.ro_clk_o = force_val;
        hist[edge_n + 1] = force_val;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic run_word(input logic noise, input int budget, output int v_edge, output int busy_cnt);
        v_edge   = -1;
        busy_cnt = 0;
        for (int i = 0; i < budget && v_edge < 0; i++) begin
            cyc(1'b1, 1'b1, noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (busy) busy_cnt++;
            if (data_valid) v_edge = edge_n;
        end
    endtask

    // Raw bit taken at edge t is the parity of the rings two edges earlier (two sync stages);
    // after counters clear at edge c, bit k is taken at edge c + DIV*k, first bit ends up in the MSB.
    function automatic logic [W-1:0] model_word(input int c);
        logic [W-1:0] w = '0;
        for (int k = 1; k <= W; k++) w = {w[W-2:0], ^hist[c + DIV * k - 2]};
        return w;
    endfunction

    int e0, ve, bc, bad_v, bad_d;
    logic [W-1:0] word;

    initial begin
        set_mode(0, '0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        check("rst_data", data_o, 0);
        check("rst_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ro", ro_clk_o, 0);
`ifdef MRO_VON_NEUMANN_EN
        cyc(1'b1, 1'b0, 1'b0);
        vn_base = edge_n + 1;
        set_mode(3, '0);
        e0 = edge_n + 1;
        run_word(1'b0, 800, ve, bc);
        check("vn_alt_edge", ve, e0 + WU + 2 * W * DIV);
        check("vn_alt_word", data_o, {W{1'b1}});
        set_mode(2, N'(1));
        cyc(1'b1, 1'b0, 1'b0);
        bad_v = 0;
        repeat (2000) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (data_valid) bad_v++;
        end
        check("vn_const_no_valid", bad_v, 0);
`else
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("idle_busy", busy, 0);

        // Free-running rings: timing only.
        e0 = edge_n + 1;
        run_word(1'b0, 600, ve, bc);
        check("lat_busy_cycles", bc, WU);
        check("lat_valid_edge", ve, e0 + WU + W * DIV);
        word  = data_o;
        bad_v = 0;
        bad_d = 0;
        repeat (1000) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (!data_valid) bad_v++;
            if (data_o !== word) bad_d++;
        end
        check("hold_valid_drops", bad_v, 0);
        check("hold_data_changes", bad_d, 0);
        cyc(1'b1, 1'b0, 1'b1);
        check("en_wins_valid", data_valid, 0);
        check("en_wins_data", data_o, 0);
        check("en_wins_busy", busy, 0);

        // Random ring patterns with ready noise outside HOLD.
        set_mode(1, '0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        e0 = edge_n + 1;
        run_word(1'b1, 600, ve, bc);
        check("rnd_valid_edge", ve, e0 + WU + W * DIV);
        check("rnd_word", data_o, model_word(e0 + WU));
        for (int n = 0; n < 4; n++) begin
            word = data_o;
            repeat ($urandom_range(0, 20)) cyc(1'b1, 1'b1, 1'b0);
            check("hold_valid", data_valid, 1);
            check("hold_data", data_o, word);
            cyc(1'b1, 1'b1, 1'b1);
            e0 = edge_n;
            check("rdy_valid_clr", data_valid, 0);
            check("rdy_data_kept", data_o, word);
            run_word(1'b1, 300, ve, bc);
            check("next_valid_edge", ve, e0 + W * DIV);
            check("next_word", data_o, model_word(e0));
        end

        // Fixed rings: odd parity gives all ones, even parity all zeros.
        set_mode(2, N'(1));
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        e0 = edge_n + 1;
        run_word(1'b0, 600, ve, bc);
        check("ring0_edge", ve, e0 + WU + W * DIV);
        check("ring0_word", data_o, {W{1'b1}});
        set_mode(2, {N{1'b1}});
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        e0 = edge_n + 1;
        run_word(1'b0, 600, ve, bc);
        check("all_rings_edge", ve, e0 + WU + W * DIV);
        check("all_rings_word", data_o, 0);

        // Abort in COLLECT, then a full restart.
        set_mode(0, '0);
        cyc(1'b1, 1'b0, 1'b0);
        e0    = edge_n + 1;
        bad_v = 0;
        while (edge_n < e0 + 299) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (data_valid) bad_v++;
        end
        cyc(1'b1, 1'b0, 1'b0);
        check("abort_busy", busy, 0);
        repeat (100) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (data_valid) bad_v++;
        end
        check("abort_no_valid", bad_v, 0);
        e0 = edge_n + 1;
        run_word(1'b0, 600, ve, bc);
        check("abort_busy_cycles", bc, WU);
        check("abort_valid_edge", ve, e0 + WU + W * DIV);

        // Reset mid-collect discards progress; restart needs a full warmup.
        set_mode(1, '0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (320) cyc(1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        check("midrst_data", data_o, 0);
        check("midrst_valid", data_valid, 0);
        check("midrst_busy", busy, 0);
        e0 = edge_n + 1;
        run_word(1'b0, 600, ve, bc);
        check("midrst_busy_cycles", bc, WU);
        check("midrst_valid_edge", ve, e0 + WU + W * DIV);
        check("midrst_word", data_o, model_word(e0 + WU));
`endif
        set_mode(0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mro_trng.md
MRO_TRNG -- requirements
Module: mro_trng

Interface
REQ-001 Parameter N_RO, default 32, number of ring oscillators instantiated.
REQ-002 Parameter RO_LEN, default 20, stage count passed to every ring cell.
REQ-003 Parameter WARMUP_CYC, default 256, CLK cycles rings run before sampling begins; legal range >=1.
REQ-004 Parameter SAMPLE_DIV, default 4, CLK cycles per raw-bit sample tick; legal range >=1.
REQ-005 Parameter OUT_W, default 32, output word width; legal range >=2.
REQ-006 CLK  in  1  single system clock; all flops rising-edge.
REQ-007 RESET_N  in  1  synchronous, active-low reset.
REQ-008 EN  in  1  run request; 0 holds all rings in reset.
REQ-009 DATA_READY  in  1  consumer accepts DATA_O when DATA_VALID=1.
REQ-010 DATA_O  out  OUT_W  random word.
REQ-011 DATA_VALID  out  1  DATA_O holds a complete word.
REQ-012 BUSY  out  1  high while in WARMUP.
REQ-013 RO_CLK_O  out  N_RO  raw ring outputs, KEEP-attributed, for debug/test.

Function
REQ-014 Rings SHALL be held in reset whenever RESET_N=0 or state=IDLE.
REQ-015 Each RO_CLK_O bit SHALL pass a 2-flop synchronizer (reset 0); raw bit r = XOR of all N_RO second-stage bits.
REQ-016 FSM states IDLE, WARMUP, COLLECT, HOLD; IDLE->WARMUP on the edge EN is sampled 1 (edge E0).
REQ-017 WARMUP: counter 0..WARMUP_CYC-1, BUSY=1; at terminal count -> COLLECT, divider and bit count cleared.
REQ-018 COLLECT: divider 0..SAMPLE_DIV-1; tick when divider=SAMPLE_DIV-1; each tick shifts r into shift register LSB (shreg <= {shreg[OUT_W-2:0], r}).
REQ-019 On the edge of the OUT_W-th accepted bit: DATA_O <= completed word, DATA_VALID <= 1, -> HOLD; first DATA_VALID visible after edge E0+WARMUP_CYC+OUT_W*SAMPLE_DIV (384 with defaults).
REQ-020 HOLD: DATA_O stable, DATA_VALID held, no sampling; on edge with DATA_READY=1: DATA_VALID <= 0, -> COLLECT, counters cleared, DATA_O retained.
REQ-021 DATA_READY SHALL be ignored outside HOLD.
REQ-022 EN sampled 0 in any state -> IDLE next edge; DATA_VALID, BUSY, DATA_O, counters, shreg cleared; partial/held word discarded.
REQ-023 EN=0 and DATA_READY=1 on the same edge in HOLD: EN wins, word discarded, no transfer.
REQ-024 Counters SHALL be sized ceil(log2) of their terminal count (min 1 bit); no wrap beyond terminal count.

Reset
REQ-025 RESET_N=0 on an edge: state IDLE, DATA_O=0, DATA_VALID=0, BUSY=0, all counters, shreg, synchronizers=0; dominates EN and DATA_READY.
REQ-026 Reset mid-operation SHALL discard all progress; after release, restart requires EN high and a full warmup.

Configuration
REQ-027 Macro MRO_VON_NEUMANN_EN defined: raw bits paired over consecutive ticks; 01->0, 10->1, 00/11 discarded; only emitted bits count toward OUT_W; latency data-dependent.
REQ-028 Macro undefined: every tick's r accepted directly (REQ-018/019 latency exact); no pairing logic synthesized.

Verification
REQ-029 Reset: RESET_N=0 3 cycles with EN=1, DATA_READY=1 -> DATA_O=0, DATA_VALID=0, BUSY=0, RO_CLK_O=0.
REQ-030 Latency: defaults, EN rises, DATA_READY=0 -> BUSY high 256 cycles, DATA_VALID first high after edge E0+384, stays high, DATA_O constant 1000 cycles.
REQ-031 Forced rings: ring0 output forced 1, others 0 -> DATA_O=32'hFFFF_FFFF; all N_RO=32 forced 1 -> DATA_O=32'h0000_0000.
REQ-032 Handshake: 1-cycle DATA_READY pulse in HOLD -> DATA_VALID 0 next edge; next DATA_VALID exactly 128 cycles later; DATA_READY pulses during COLLECT no effect.
REQ-033 Abort: EN dropped at edge E0+300 -> IDLE next edge, no DATA_VALID; EN reasserted -> BUSY 256 cycles, DATA_VALID at new E0+384.
REQ-034 MRO_VON_NEUMANN_EN defined: raw forced 1,0,1,0... -> DATA_O=32'hFFFF_FFFF after 64 ticks (256 collect cycles); raw constant 1 -> DATA_VALID never asserts in 2000 cycles.
